// File: rtl/i2s_tx_serializer.sv
// Transmit-side I2S data stage: buffers stereo pairs in a small FIFO and
// serializes them MSB-first on i2s_data, aligned to the audio_timing strobes.
module i2s_tx_serializer #(
   parameter int SAMPLE_WIDTH    = 16,
   parameter int FIFO_DEPTH      = 4,
   parameter int UNDERRUN_REPEAT = 0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   input  logic [SAMPLE_WIDTH-1:0]       sample_left,
   input  logic [SAMPLE_WIDTH-1:0]       sample_right,
   input  logic                          i2s_lrclk,
   input  logic                          i2s_data_shift_strobe,
   input  logic                          i2s_data_load_strobe,
   output logic                          i2s_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic [15:0]                   underrun_count
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LEVEL_W = PTR_W + 1;

   logic [SAMPLE_WIDTH-1:0] left_mem_r  [FIFO_DEPTH];
   logic [SAMPLE_WIDTH-1:0] right_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_r;
   logic [PTR_W-1:0]        rd_ptr_r;
   logic [LEVEL_W-1:0]      level_r;
   logic [LEVEL_W-1:0]      level_next_s;
   logic [15:0]             shift_r;
   logic [15:0]             shift_next_s;
   logic [15:0]             load_word_s;
   logic [SAMPLE_WIDTH-1:0] held_right_r;
   logic [SAMPLE_WIDTH-1:0] held_next_s;
   logic [SAMPLE_WIDTH-1:0] last_left_r;
   logic [SAMPLE_WIDTH-1:0] last_right_r;
   logic                    ready_s;
   logic                    push_s;
   logic                    left_load_s;
   logic                    right_load_s;
   logic                    pop_s;
   logic                    underrun_s;
   logic                    underrun_r;
   logic [15:0]             underrun_count_r;

   // Left-justify a channel word in the 16-bit shift register, zero-padding the LSBs.
   function automatic logic [15:0] align_word(input logic [SAMPLE_WIDTH-1:0] word);
      logic [15:0] aligned;
      aligned = 16'h0000;
      aligned[15 -: SAMPLE_WIDTH] = word;
      return aligned;
   endfunction

   assign ready_s      = (level_r < LEVEL_W'(FIFO_DEPTH));
   assign push_s       = sample_valid && ready_s;
   assign left_load_s  = i2s_data_load_strobe && !i2s_lrclk;
   assign right_load_s = i2s_data_load_strobe && i2s_lrclk;
   // Pop and underrun both look at the registered level, so a same-edge push is invisible to them.
   assign pop_s        = left_load_s && (level_r != {LEVEL_W{1'b0}});
   assign underrun_s   = left_load_s && (level_r == {LEVEL_W{1'b0}});

   // Next FIFO occupancy from this edge's push/pop pair.
   always_comb begin
      level_next_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LEVEL_W'(1);
         2'b01:   level_next_s = level_r - LEVEL_W'(1);
         default: level_next_s = level_r;
      endcase
   end

   // Word selected by a load event and the right word held for the following half-frame.
   always_comb begin
      load_word_s = 16'h0000;
      held_next_s = held_right_r;
      if (left_load_s) begin
         if (pop_s) begin
            load_word_s = align_word(left_mem_r[rd_ptr_r]);
            held_next_s = right_mem_r[rd_ptr_r];
         end else if (UNDERRUN_REPEAT != 0) begin
            load_word_s = align_word(last_left_r);
            held_next_s = last_right_r;
         end else begin
            load_word_s = 16'h0000;
            held_next_s = {SAMPLE_WIDTH{1'b0}};
         end
      end else if (right_load_s) begin
         load_word_s = align_word(held_right_r);
         held_next_s = held_right_r;
      end else begin
         load_word_s = 16'h0000;
         held_next_s = held_right_r;
      end
   end

   // Shift register update; a load on the same edge as a shift takes priority.
   always_comb begin
      shift_next_s = shift_r;
      if (i2s_data_load_strobe) begin
         shift_next_s = load_word_s;
      end else if (i2s_data_shift_strobe) begin
         shift_next_s = {shift_r[14:0], 1'b0};
      end else begin
         shift_next_s = shift_r;
      end
   end

   // FIFO storage; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         left_mem_r[wr_ptr_r]  <= sample_left;
         right_mem_r[wr_ptr_r] <= sample_right;
      end
   end

   // Pointers, level, serializer state and underrun bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r         <= {PTR_W{1'b0}};
         rd_ptr_r         <= {PTR_W{1'b0}};
         level_r          <= {LEVEL_W{1'b0}};
         shift_r          <= 16'h0000;
         held_right_r     <= {SAMPLE_WIDTH{1'b0}};
         last_left_r      <= {SAMPLE_WIDTH{1'b0}};
         last_right_r     <= {SAMPLE_WIDTH{1'b0}};
         underrun_r       <= 1'b0;
         underrun_count_r <= 16'h0000;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r     <= rd_ptr_r + PTR_W'(1);
            last_left_r  <= left_mem_r[rd_ptr_r];
            last_right_r <= right_mem_r[rd_ptr_r];
         end
         level_r      <= level_next_s;
         shift_r      <= shift_next_s;
         held_right_r <= held_next_s;
         underrun_r   <= underrun_s;
         if (underrun_s && (underrun_count_r != 16'hFFFF)) begin
            underrun_count_r <= underrun_count_r + 16'd1;
         end
      end
   end

   assign sample_ready   = ready_s;
   assign i2s_data       = shift_r[15];
   assign fifo_level     = level_r;
   assign underrun       = underrun_r;
   assign underrun_count = underrun_count_r;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: two instances (zero-fill and repeat
// underrun policies) share stimulus and are checked against a scoreboard model.
module tb_i2s_tx_serializer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_left = 16'h0000;
   logic [15:0] sample_right = 16'h0000;
   logic        i2s_lrclk = 1'b0;
   logic        shift_strobe = 1'b0;
   logic        load_strobe = 1'b0;

   logic        ready0, ready1, data0, data1, und0, und1;
   logic [2:0]  level0, level1;
   logic [15:0] count0, count1;

   i2s_tx_serializer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(4), .UNDERRUN_REPEAT(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_ready(ready0),
      .sample_left(sample_left), .sample_right(sample_right), .i2s_lrclk(i2s_lrclk),
      .i2s_data_shift_strobe(shift_strobe), .i2s_data_load_strobe(load_strobe),
      .i2s_data(data0), .fifo_level(level0), .underrun(und0), .underrun_count(count0));

   i2s_tx_serializer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(4), .UNDERRUN_REPEAT(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_ready(ready1),
      .sample_left(sample_left), .sample_right(sample_right), .i2s_lrclk(i2s_lrclk),
      .i2s_data_shift_strobe(shift_strobe), .i2s_data_load_strobe(load_strobe),
      .i2s_data(data1), .fifo_level(level1), .underrun(und1), .underrun_count(count1));

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   logic [15:0] m_sh0, m_sh1, m_held0, m_held1, m_last_l, m_last_r;
   int          m_uc;
   logic        m_und;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_sh0 = 16'h0000; m_sh1 = 16'h0000;
      m_held0 = 16'h0000; m_held1 = 16'h0000;
      m_last_l = 16'h0000; m_last_r = 16'h0000;
      m_uc = 0; m_und = 1'b0;
   endtask

   // One clock of stimulus: predict the edge, drive it, then check every output.
   task automatic step(input logic ld, input logic sh, input logic lr, input logic val,
                       input logic [15:0] l, input logic [15:0] r);
      logic [31:0] pr;
      logic        rdy;
      rdy = (q.size() < 4);
      chk("sample_ready", 32'(ready0), 32'(rdy));
      chk("sample_ready_rep", 32'(ready1), 32'(rdy));
      sample_valid = val; sample_left = l; sample_right = r;
      i2s_lrclk = lr; load_strobe = ld; shift_strobe = sh;
      m_und = 1'b0;
      if (ld && !lr) begin
         if (q.size() != 0) begin
            pr = q.pop_front();
            m_sh0 = pr[31:16]; m_sh1 = pr[31:16];
            m_held0 = pr[15:0]; m_held1 = pr[15:0];
            m_last_l = pr[31:16]; m_last_r = pr[15:0];
         end else begin
            m_und = 1'b1;
            if (m_uc < 65535) m_uc++;
            m_sh0 = 16'h0000; m_held0 = 16'h0000;
            m_sh1 = m_last_l; m_held1 = m_last_r;
         end
      end else if (ld) begin
         m_sh0 = m_held0; m_sh1 = m_held1;
      end else if (sh) begin
         m_sh0 = {m_sh0[14:0], 1'b0}; m_sh1 = {m_sh1[14:0], 1'b0};
      end
      if (val && rdy) q.push_back({l, r});
      @(posedge clk); #1;
      sample_valid = 1'b0; load_strobe = 1'b0; shift_strobe = 1'b0;
      chk("i2s_data", 32'(data0), 32'(m_sh0[15]));
      chk("i2s_data_rep", 32'(data1), 32'(m_sh1[15]));
      chk("underrun", 32'(und0), 32'(m_und));
      chk("underrun_rep", 32'(und1), 32'(m_und));
      chk("fifo_level", 32'(level0), 32'(q.size()));
      chk("fifo_level_rep", 32'(level1), 32'(q.size()));
      chk("underrun_count", 32'(count0), 32'(m_uc));
      chk("underrun_count_rep", 32'(count1), 32'(m_uc));
   endtask

   // One stereo frame: load+shift on the first BCLK of each half, shift on the rest.
   task automatic frame(input int div);
      logic lr_v;
      for (int h = 0; h < 2; h++) begin
         lr_v = (h == 1);
         for (int b = 0; b < 16; b++) begin
            step(b == 0, 1'b1, lr_v, 1'b0, 16'h0000, 16'h0000);
            for (int k = 1; k < div; k++) step(1'b0, 1'b0, lr_v, 1'b0, 16'h0000, 16'h0000);
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("idle_data", 32'(data0), 32'h0);
      chk("idle_level", 32'(level0), 32'h0);
      chk("idle_ready", 32'(ready0), 32'h1);
      chk("idle_count", 32'(count0), 32'h0);

      // One pair through a frame at the 27 MHz / 44.1 kHz BCLK spacing
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'hCAFE, 16'hBABE);
      chk("cafe_level", 32'(level0), 32'h1);
      frame(19);
      chk("cafe_drained", 32'(level0), 32'h0);

      // Five back-to-back pushes into a depth-4 FIFO
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, 1'b0, 1'b1, 16'(16'h1100 + i), 16'(16'hEE00 - i));
      chk("full_ready", 32'(ready0), 32'h0);
      chk("full_level", 32'(level0), 32'h4);
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'h1104, 16'hEDFC);
      chk("held_push_pop_level", 32'(level0), 32'h3);
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1104, 16'hEDFC);
      chk("held_push_level", 32'(level0), 32'h4);
      for (int i = 0; i < 4; i++) frame(2);

      // Underruns: zero policy vs repeat of the last pair
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 16'h7FFE);
      frame(2);
      for (int i = 0; i < 3; i++) frame(2);
      chk("underrun_count_3", 32'(count0), 32'h3);
      chk("underrun_count_3_rep", 32'(count1), 32'h3);

      // Pop-on-empty with a same-edge push, then load+shift collision
      step(1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5, 16'h0F0F);
      chk("empty_push_level", 32'(level0), 32'h1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("load_shift_msb", 32'(data0), 32'h1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678);
      chk("after_load_shift", 32'(data0), 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("bit13", 32'(data0), 32'h1);

      // Asynchronous reset mid-word
      #2 reset_n = 1'b0;
      #1;
      chk("rst_data", 32'(data0), 32'h0);
      chk("rst_level", 32'(level0), 32'h0);
      chk("rst_ready", 32'(ready0), 32'h1);
      chk("rst_count", 32'(count0), 32'h0);
      chk("rst_underrun", 32'(und0), 32'h0);
      model_reset();
      @(posedge clk); #1 reset_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("post_rst_underrun", 32'(und0), 32'h1);
      frame(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
